// File: rtl/systolic_ctrl.sv
// Systolic array sequencer: loads N weight rows, streams K data vectors,
// waits for the skewed wavefront to leave the array, then pulses done.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | waiting for start with a non-zero vector count
// LOAD_W  | N cycles shifting weights in, farthest row first
// COMPUTE | K cycles reading data vectors at addresses 0..K-1
// DRAIN   | N + N*PE_LAT cycles for the last results to emerge
// DONE    | one-cycle completion pulse
module systolic_ctrl #(
    parameter int N      = 4,
    parameter int PE_LAT = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vec,
    output logic             busy,
    output logic             done,
    output logic             pe_cntrl,
    output logic             w_rd_en,
    output logic [CNT_W-1:0] w_addr,
    output logic             d_rd_en,
    output logic [CNT_W-1:0] d_addr,
    output logic [N-1:0]     row_valid,
    output logic [N-1:0]     col_valid
);

    // Drain length equals the longest delay tap (last column's result valid).
    localparam int D  = N + N * PE_LAT;
    localparam int DW = $clog2(D);
    localparam int CW = (DW > CNT_W) ? DW : CNT_W;
    localparam logic [CW-1:0]    C_ONE = 1;
    localparam logic [CNT_W-1:0] A_ONE = 1;

    typedef enum logic [2:0] {IDLE, LOAD_W, COMPUTE, DRAIN, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [CNT_W-1:0] k;
    logic [D-1:0]     dly;

    // Sequencer: down-counter per phase, all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            k        <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_cntrl <= 1'b0;
            w_rd_en  <= 1'b0;
            w_addr   <= '0;
            d_rd_en  <= 1'b0;
            d_addr   <= '0;
        end else if (abort && state != IDLE) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pe_cntrl <= 1'b0;
            w_rd_en  <= 1'b0;
            w_addr   <= '0;
            d_rd_en  <= 1'b0;
            d_addr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && num_vec != '0) begin
                        state    <= LOAD_W;
                        k        <= num_vec;
                        cnt      <= CW'(N - 1);
                        busy     <= 1'b1;
                        pe_cntrl <= 1'b1;
                        w_rd_en  <= 1'b1;
                        w_addr   <= CNT_W'(N - 1);
                    end
                end
                LOAD_W: begin
                    if (cnt == '0) begin
                        state    <= COMPUTE;
                        cnt      <= CW'(k) - C_ONE;
                        pe_cntrl <= 1'b0;
                        w_rd_en  <= 1'b0;
                        w_addr   <= '0;
                        d_rd_en  <= 1'b1;
                        d_addr   <= '0;
                    end else begin
                        cnt    <= cnt - C_ONE;
                        w_addr <= w_addr - A_ONE;
                    end
                end
                COMPUTE: begin
                    if (cnt == '0) begin
                        state   <= DRAIN;
                        cnt     <= CW'(D - 1);
                        d_rd_en <= 1'b0;
                        d_addr  <= '0;
                    end else begin
                        cnt    <= cnt - C_ONE;
                        d_addr <= d_addr + A_ONE;
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - C_ONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Valid delay line: tap m is d_rd_en delayed m+1 cycles; wiped on abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            dly <= '0;
        end else if (abort && state != IDLE) begin
            dly <= '0;
        end else begin
            dly <= {dly[D-2:0], d_rd_en};
        end
    end

    // Row i taps delay i+1; column j taps delay 1+j+N*PE_LAT.
    assign row_valid = dly[N-1:0];
    assign col_valid = dly[D-1:N*PE_LAT];

endmodule

// File: tb/tb_systolic_ctrl.sv
// Directed bench for systolic_ctrl with a job-timeline reference model.
module tb_systolic_ctrl;
    localparam int N  = 4;
    localparam int PL = 3;
    localparam int AW = 8;
    localparam int D  = N + N * PL;

    logic          clk = 1'b0;
    logic          reset, start, abort;
    logic [AW-1:0] num_vec;
    logic          busy, done, pe_cntrl, w_rd_en, d_rd_en;
    logic [AW-1:0] w_addr, d_addr;
    logic [N-1:0]  row_valid, col_valid;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int js     = -1;
    int jk     = 0;
    bit chk_en = 1'b0;

    systolic_ctrl #(.N(N), .PE_LAT(PL), .CNT_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .num_vec(num_vec),
        .busy(busy), .done(done), .pe_cntrl(pe_cntrl), .w_rd_en(w_rd_en), .w_addr(w_addr),
        .d_rd_en(d_rd_en), .d_addr(d_addr), .row_valid(row_valid), .col_valid(col_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Model: track the start cycle of the live job; a job is alive for cycles 1..total after it.
    always @(posedge clk) begin
        automatic int  c   = cyc;
        automatic bit  act = (js >= 0) && (c - js >= 1) && (c - js <= N + jk + D + 1);
        if (reset) begin
            js = -1;
            chk_en = 1'b1;
        end else if (!act && start && num_vec != 0) begin
            js = c;
            jk = int'(num_vec);
        end else if (act && abort) begin
            js = -1;
        end
        cyc = c + 1;
    end

    // Expected outputs from the job's phase boundaries, checked every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            automatic int t   = (js >= 0) ? cyc - js : -100000;
            automatic int tot = N + jk + D + 1;
            automatic logic       e_busy = (t >= 1 && t <= tot);
            automatic logic       e_pe   = (t >= 1 && t <= N);
            automatic logic       e_drd  = (t >= N + 1 && t <= N + jk);
            automatic logic [7:0] e_wa   = e_pe  ? 8'(N - t) : 8'd0;
            automatic logic [7:0] e_da   = e_drd ? 8'(t - N - 1) : 8'd0;
            automatic logic [N-1:0] e_rv = '0;
            automatic logic [N-1:0] e_cv = '0;
            for (int i = 0; i < N; i++) begin
                e_rv[i] = (t >= N + 2 + i) && (t <= N + jk + 1 + i);
                e_cv[i] = (t >= N + 2 + i + N * PL) && (t <= N + jk + 1 + i + N * PL);
            end
            chk("busy", 32'(busy), 32'(e_busy));
            chk("done", 32'(done), 32'(t == tot));
            chk("pe_cntrl", 32'(pe_cntrl), 32'(e_pe));
            chk("w_rd_en", 32'(w_rd_en), 32'(e_pe));
            chk("w_addr", 32'(w_addr), 32'(e_wa));
            chk("d_rd_en", 32'(d_rd_en), 32'(e_drd));
            chk("d_addr", 32'(d_addr), 32'(e_da));
            chk("row_valid", 32'(row_valid), 32'(e_rv));
            chk("col_valid", 32'(col_valid), 32'(e_cv));
        end
    end

    // Inputs set during the current cycle are sampled at its closing edge.
    task automatic step(input logic s, input logic [AW-1:0] nv, input logic a, input logic r);
        start   = s;
        num_vec = nv;
        abort   = a;
        reset   = r;
        @(negedge clk);
    endtask

    initial begin
        int t0, rel, ndone, ncol;
        reset = 1'b1; start = 1'b0; abort = 1'b0; num_vec = '0;
        @(negedge clk);
        step(1'b1, 8'd3, 1'b1, 1'b1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'({row_valid, col_valid}), 32'd0);

        // Basic K=3 job; a second start mid-job must be ignored.
        t0 = cyc; ndone = 0;
        step(1'b1, 8'd3, 1'b0, 1'b0);
        while (cyc - t0 <= 30) begin
            rel = cyc - t0;
            if (done) ndone++;
            if (rel == 1)  chk("lit_waddr1", 32'(w_addr), 32'd3);
            if (rel == 4)  chk("lit_pe4", 32'(pe_cntrl), 32'd1);
            if (rel == 5)  chk("lit_pe5", 32'(pe_cntrl), 32'd0);
            if (rel == 7)  chk("lit_daddr7", 32'(d_addr), 32'd2);
            if (rel == 6)  chk("lit_rv6", 32'(row_valid), 32'h1);
            if (rel == 11) chk("lit_rv11", 32'(row_valid), 32'h8);
            if (rel == 18) chk("lit_cv18", 32'(col_valid), 32'h1);
            if (rel == 23) chk("lit_cv23", 32'(col_valid), 32'h8);
            if (rel == 24) chk("lit_done24", 32'(done), 32'd1);
            if (rel == 25) chk("lit_busy25", 32'(busy), 32'd0);
            step(rel == 10, 8'd3, 1'b0, 1'b0);
        end
        chk("single_done", 32'(ndone), 32'd1);

        // Start with zero count is ignored; abort in IDLE does nothing.
        step(1'b1, 8'd0, 1'b0, 1'b0);
        chk("nv0_busy", 32'(busy), 32'd0);
        step(1'b0, 8'd5, 1'b1, 1'b0);
        step(1'b0, 8'd5, 1'b0, 1'b0);

        // Abort during COMPUTE.
        t0 = cyc; ndone = 0; ncol = 0;
        step(1'b1, 8'd3, 1'b0, 1'b0);
        while (cyc - t0 <= 28) begin
            rel = cyc - t0;
            if (done) ndone++;
            if (col_valid != 0) ncol++;
            if (rel == 7) chk("lit_abort_busy7", 32'(busy), 32'd0);
            step(1'b0, 8'd3, rel == 6, 1'b0);
        end
        chk("abort_no_done", 32'(ndone), 32'd0);
        chk("abort_no_col", 32'(ncol), 32'd0);

        // Reset mid-job, then a clean job from cycle 20.
        t0 = cyc; ndone = 0;
        step(1'b1, 8'd3, 1'b0, 1'b0);
        while (cyc - t0 <= 46) begin
            rel = cyc - t0;
            if (done) ndone++;
            if (rel == 16) chk("lit_rst_busy16", 32'(busy), 32'd0);
            if (rel == 44) chk("lit_done44", 32'(done), 32'd1);
            step(rel == 20, 8'd3, 1'b0, rel == 15);
        end
        chk("reset_one_done", 32'(ndone), 32'd1);

        // Abort and start together in IDLE: start wins.
        t0 = cyc;
        step(1'b1, 8'd2, 1'b1, 1'b0);
        while (cyc - t0 <= 26) begin
            rel = cyc - t0;
            if (rel == 1) chk("lit_abst_busy1", 32'(busy), 32'd1);
            if (rel == 23) chk("lit_abst_done23", 32'(done), 32'd1);
            step(1'b0, 8'd2, 1'b0, 1'b0);
        end

        // Back-to-back with start held high, K=1.
        t0 = cyc;
        while (cyc - t0 <= 47) begin
            rel = cyc - t0;
            if (rel == 22) chk("lit_b2b_done22", 32'(done), 32'd1);
            if (rel == 23) chk("lit_b2b_pe23", 32'(pe_cntrl), 32'd0);
            if (rel == 24) chk("lit_b2b_pe24", 32'(pe_cntrl), 32'd1);
            if (rel == 45) chk("lit_b2b_done45", 32'(done), 32'd1);
            step(rel <= 40, 8'd1, 1'b0, 1'b0);
        end
        step(1'b0, 8'd1, 1'b0, 1'b0);
        repeat (25) step(1'b0, 8'd0, 1'b0, 1'b0);

        // Maximum count: address must reach 254 without wrapping.
        t0 = cyc;
        step(1'b1, 8'd255, 1'b0, 1'b0);
        while (cyc - t0 <= 280) begin
            rel = cyc - t0;
            if (rel == 259) chk("lit_k255_daddr", 32'(d_addr), 32'd254);
            if (rel == 276) chk("lit_k255_done", 32'(done), 32'd1);
            step(1'b0, 8'd0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/systolic_ctrl.md
SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

Interface
REQ-001 Parameter N, default 4: array dimension (N x N PEs), range 2..16.
REQ-002 Parameter PE_LAT, default 3: per-PE cycles from data_in to acc_out.
REQ-003 Parameter CNT_W, default 8: width of vector count and addresses.
REQ-004 clk  in  1: clock; all logic SHALL be rising-edge.
REQ-005 reset  in  1: reset, synchronous, active-high.
REQ-006 start  in  1: request one job; sampled only in IDLE.
REQ-007 abort  in  1: synchronous job cancel.
REQ-008 num_vec  in  CNT_W: number of input vectors K for the job.
REQ-009 busy  out  1: high whenever state is not IDLE.
REQ-010 done  out  1: one-cycle job-complete pulse.
REQ-011 pe_cntrl  out  1: weight-shift enable to all PEs.
REQ-012 w_rd_en / w_addr  out  1 / CNT_W: weight buffer read strobe and address.
REQ-013 d_rd_en / d_addr  out  1 / CNT_W: data buffer read strobe and address.
REQ-014 row_valid  out  N: per-row skewed data-valid to array inputs.
REQ-015 col_valid  out  N: per-column result-valid at array outputs.

Function
REQ-016 States SHALL be IDLE, LOAD_W, COMPUTE, DRAIN, DONE, one-hot or binary; all outputs registered.
REQ-017 IDLE: start=1 and num_vec!=0 SHALL latch K=num_vec and enter LOAD_W next cycle; start with num_vec=0 SHALL be ignored.
REQ-018 LOAD_W SHALL last exactly N cycles with pe_cntrl=1, w_rd_en=1, w_addr = N-1 down to 0 (farthest row first), then enter COMPUTE.
REQ-019 COMPUTE SHALL last exactly K cycles with d_rd_en=1, d_addr = 0..K-1 incrementing, then enter DRAIN.
REQ-020 DRAIN SHALL last exactly D = N + N*PE_LAT cycles, then enter DONE.
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 pe_cntrl, w_rd_en, d_rd_en SHALL be 0 outside their states; w_addr/d_addr SHALL hold 0 when not reading.
REQ-023 row_valid[i] SHALL equal d_rd_en delayed i+1 cycles (1 cycle buffer read latency plus row skew).
REQ-024 col_valid[j] SHALL equal d_rd_en delayed 1+j+N*PE_LAT cycles; last col_valid[N-1] pulse SHALL fall in the final DRAIN cycle.
REQ-025 Delay lines SHALL be shift registers of the exact length; no counter-based approximation.
REQ-026 start while busy=1 SHALL be ignored; no queuing.
REQ-027 K=255 (max for CNT_W=8) SHALL work; d_addr SHALL not wrap within a job.
REQ-028 abort=1 in any non-IDLE state SHALL enter IDLE next cycle, clear all delay lines, suppress done; abort in IDLE has no effect.
REQ-029 abort and start in the same IDLE cycle: start SHALL win (abort ignored in IDLE).

Reset
REQ-030 reset SHALL force IDLE and clear busy, done, pe_cntrl, w_rd_en, d_rd_en, w_addr, d_addr, row_valid, col_valid, K and all delay lines to 0.
REQ-031 reset SHALL override abort and start; reset mid-job SHALL produce no done and no further valid pulses.

Verification (N=4, PE_LAT=3, start sampled at cycle 0)
REQ-032 start, K=3 -> pe_cntrl/w_rd_en cycles 1-4, w_addr 3,2,1,0; d_rd_en cycles 5-7, d_addr 0,1,2; done at cycle 24 only; busy cycles 1-24.
REQ-033 Same job -> row_valid[0] cycles 6-8, row_valid[3] cycles 9-11; col_valid[0] cycles 18-20, col_valid[3] cycles 21-23.
REQ-034 start with num_vec=0 -> busy stays 0, no strobes; start asserted again at cycle 10 of a K=3 job -> ignored, single done at 24.
REQ-035 abort at cycle 6 of K=3 job -> IDLE at cycle 7, all outputs 0 from cycle 7, no done, no col_valid pulses.
REQ-036 reset at cycle 15 of K=3 job -> all outputs 0 from cycle 16; new start at cycle 20 runs a full clean job (done at cycle 44).
REQ-037 Back-to-back: start held high, K=1 -> done at cycle 22, next job LOAD_W begins cycle 24.
